// File: rtl/load_store_unit.sv
// RV32I load/store unit: one in-flight access over a req/ack memory port.
// Handles lane steering, load extension, alignment checks and ack timeout.
module load_store_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        is_store,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [31:0] rdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [1:0]  state;
  logic        store_q;
  logic [2:0]  f3_q;
  logic [1:0]  off_q;
  logic [3:0]  be_q;
  logic        err_q;
  logic [31:0] tmo_cnt;

  logic        is_b;
  logic        is_h;
  logic        is_w;
  logic        legal;
  logic        misal;
  logic [3:0]  be_n;
  logic [31:0] wd_n;
  logic [7:0]  lane_b;
  logic [15:0] lane_h;
  logic [31:0] ld_ext;
  logic        tmo_hit;

  assign is_b = funct3[1:0] == 2'b00;
  assign is_h = funct3[1:0] == 2'b01;
  assign is_w = funct3 == 3'b010;

  always_comb begin
    legal = 1'b0;
    if (!funct3[2] && funct3[1:0] != 2'b11)
      legal = 1'b1;
    else if (!is_store && funct3[2] && !funct3[1])
      legal = 1'b1;
  end

  assign misal = (is_h && addr[0]) ||
                 (is_w && addr[1:0] != 2'b00);

  always_comb begin
    be_n = 4'b1111;
    wd_n = wdata;
    unique case (1'b1)
      is_b: begin
        be_n = 4'b0001 << addr[1:0];
        wd_n = {4{wdata[7:0]}};
      end
      is_h: begin
        be_n = 4'b0011 << addr[1:0];
        wd_n = {2{wdata[15:0]}};
      end
      default: ;
    endcase
  end

  assign lane_b = mem_rdata[{off_q, 3'b000} +: 8];
  assign lane_h = mem_rdata[{off_q[1], 4'b0000} +: 16];

  always_comb begin
    ld_ext = mem_rdata;
    unique case (f3_q)
      3'b000:  ld_ext = {{24{lane_b[7]}}, lane_b};
      3'b001:  ld_ext = {{16{lane_h[15]}}, lane_h};
      3'b100:  ld_ext = {24'd0, lane_b};
      3'b101:  ld_ext = {16'd0, lane_h};
      default: ld_ext = mem_rdata;
    endcase
  end

  // Counter holds the number of ack-less REQ cycles already completed.
  assign tmo_hit = (TIMEOUT_CYCLES != 0) &&
                   (tmo_cnt == TIMEOUT_CYCLES - 32'd1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      store_q   <= 1'b0;
      f3_q      <= 3'b000;
      off_q     <= 2'b00;
      be_q      <= 4'b0000;
      err_q     <= 1'b0;
      tmo_cnt   <= 32'd0;
      rdata     <= 32'd0;
      mem_addr  <= 32'd0;
      mem_wdata <= 32'd0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (start) begin
            store_q   <= is_store;
            f3_q      <= funct3;
            off_q     <= addr[1:0];
            be_q      <= be_n;
            mem_addr  <= {addr[31:2], 2'b00};
            mem_wdata <= wd_n;
            tmo_cnt   <= 32'd0;
            if (legal && !misal) begin
              state <= S_REQ;
              err_q <= 1'b0;
            end else begin
              state <= S_RESP;
              err_q <= 1'b1;
            end
          end
        end
        S_REQ: begin
          if (mem_ack) begin
            if (!store_q)
              rdata <= ld_ext;
            err_q <= 1'b0;
            state <= S_RESP;
          end else if (tmo_hit) begin
            err_q <= 1'b1;
            state <= S_RESP;
          end else begin
            tmo_cnt <= tmo_cnt + 32'd1;
          end
        end
        S_RESP: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign busy    = state != S_IDLE;
  assign done    = state == S_RESP;
  assign err     = done && err_q;
  assign mem_req = state == S_REQ;
  assign mem_we  = mem_req && store_q;
  assign mem_be  = mem_req ? be_q : 4'b0000;

endmodule
